tbird_seq_ctrl: RTL and testbench



---
 rtl/tbird_pkg.sv | 15 +
 rtl/tbird_tick_gen.sv | 41 ++++
 rtl/tbird_seq_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_tbird_seq_ctrl.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tbird_pkg.sv
// rtl/tbird_pkg.sv - shared state type and constants for the tail-light sequencer
//   state_e     : sequencer state encoding (also driven out on state_o)
//   SYNC_STAGES : depth of the pushbutton synchroniser
package tbird_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LEFT   = 2'd1,
    RIGHT  = 2'd2,
    HAZARD = 2'd3
  } state_e;

  localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/tbird_tick_gen.sv
// rtl/tbird_tick_gen.sv - step-tick generator for the tail-light sequencer
//   clock : system clock
//   reset : synchronous active-high reset
//   clr   : restart the step count (driven on every state change)
//   tick  : high on the last cycle of each STEP_TICKS-long step
module tbird_tick_gen #(
  parameter int STEP_TICKS = 12500000
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int            CW       = $clog2(STEP_TICKS);
  localparam logic [CW-1:0] CNT_LAST = CW'(STEP_TICKS - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // clr wins over the free-running count so a freshly entered state
  // always gets a full-length first step.
  always_comb begin
    if (clr || (cnt_q == CNT_LAST)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == CNT_LAST);

endmodule

// File: rtl/tbird_seq_ctrl.sv
// rtl/tbird_seq_ctrl.sv - turn-signal / hazard sequencer for the tail-light demo
//   clock        : system clock
//   reset        : synchronous active-high reset
//   left_btn_n   : left request, active-low, asynchronous
//   right_btn_n  : right request, active-low, asynchronous
//   hazard_btn_n : hazard request, active-low, asynchronous
//   brake_btn_n  : brake request, active-low, asynchronous (only with TBIRD_BRAKE_EN)
//   left_leds    : left lamps, bit 0 innermost
//   right_leds   : right lamps, bit 0 innermost
//   state_o      : current sequencer state
// Optional feature macro: TBIRD_BRAKE_EN (brake input forcing non-sweeping lamps on)
module tbird_seq_ctrl
  import tbird_pkg::*;
#(
  parameter int LEDS_PER_SIDE = 3,
  parameter int STEP_TICKS    = 12500000
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     left_btn_n,
  input  logic                     right_btn_n,
  input  logic                     hazard_btn_n,
`ifdef TBIRD_BRAKE_EN
  input  logic                     brake_btn_n,
`endif
  output logic [LEDS_PER_SIDE-1:0] left_leds,
  output logic [LEDS_PER_SIDE-1:0] right_leds,
  output logic [1:0]               state_o
);

  localparam int            PW         = $clog2(LEDS_PER_SIDE + 1);
  localparam logic [PW-1:0] PHASE_LAST = PW'(LEDS_PER_SIDE);

  localparam int BTN_LEFT   = 0;
  localparam int BTN_RIGHT  = 1;
  localparam int BTN_HAZARD = 2;

  // ---------------------------------------------------------------------------
  // Pushbutton synchroniser: all buttons travel together through the same
  // shift chain; stages reset to 1 so nothing looks pressed out of reset.
  // ---------------------------------------------------------------------------
`ifdef TBIRD_BRAKE_EN
  localparam int NBTN      = 4;
  localparam int BTN_BRAKE = 3;
  logic [NBTN-1:0] btn_n;
  assign btn_n = {brake_btn_n, hazard_btn_n, right_btn_n, left_btn_n};
`else
  localparam int NBTN = 3;
  logic [NBTN-1:0] btn_n;
  assign btn_n = {hazard_btn_n, right_btn_n, left_btn_n};
`endif

  logic [NBTN-1:0] sync_q [SYNC_STAGES];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '1;
      end
    end else begin
      sync_q[0] <= btn_n;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
    end
  end

  logic [NBTN-1:0] req;
  logic            left_req;
  logic            right_req;
  logic            hazard_req;

  assign req        = ~sync_q[SYNC_STAGES-1];
  assign left_req   = req[BTN_LEFT];
  assign right_req  = req[BTN_RIGHT];
  assign hazard_req = req[BTN_HAZARD];

  // ---------------------------------------------------------------------------
  // Step timing
  // ---------------------------------------------------------------------------
  state_e        state_q;
  state_e        state_d;
  logic [PW-1:0] phase_q;
  logic [PW-1:0] phase_d;
  logic          state_chg;
  logic          tick;

  tbird_tick_gen #(
    .STEP_TICKS (STEP_TICKS)
  ) u_tick_gen (
    .clock (clock),
    .reset (reset),
    .clr   (state_chg),
    .tick  (tick)
  );

  // ---------------------------------------------------------------------------
  // Sequencer next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    case (state_q)
      IDLE: begin
        // Both turn requests together are treated as a hazard request.
        if (hazard_req || (left_req && right_req)) begin
          state_d = HAZARD;
        end else if (left_req) begin
          state_d = LEFT;
        end else if (right_req) begin
          state_d = RIGHT;
        end
      end
      LEFT, RIGHT: begin
        // The opposite turn request is deliberately not looked at here.
        if (hazard_req) begin
          state_d = HAZARD;
        end else if (tick) begin
          if (phase_q == PHASE_LAST) begin
            state_d = IDLE;
          end else begin
            phase_d = phase_q + PW'(1);
          end
        end
      end
      HAZARD: begin
        if (!hazard_req && !(left_req && right_req)) begin
          state_d = IDLE;
        end else if (tick) begin
          // Only bit 0 is used while flashing, so wrapping is harmless.
          phase_d = phase_q + PW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    state_chg = (state_d != state_q);
    if (state_chg) begin
      phase_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      phase_q <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
    end
  end

  assign state_o = state_q;

  // ---------------------------------------------------------------------------
  // Lamp decode: only registered state/phase feed this, so raw button edges
  // can never glitch the lamps (brake goes through the synchroniser too).
  // ---------------------------------------------------------------------------
  logic [LEDS_PER_SIDE-1:0] sweep;
  logic [LEDS_PER_SIDE-1:0] flash;

  // Thermometer of width phase: lamp i is lit once phase has passed it.
  always_comb begin
    sweep = '0;
    for (int i = 0; i < LEDS_PER_SIDE; i++) begin
      sweep[i] = (int'(phase_q) > i);
    end
  end

  // Lamps are on for the first step after entry and toggle every tick.
  assign flash = {LEDS_PER_SIDE{~phase_q[0]}};

  always_comb begin
    left_leds  = '0;
    right_leds = '0;
    case (state_q)
      LEFT:    left_leds  = sweep;
      RIGHT:   right_leds = sweep;
      HAZARD: begin
        left_leds  = flash;
        right_leds = flash;
      end
      default: begin
        left_leds  = '0;
        right_leds = '0;
      end
    endcase
`ifdef TBIRD_BRAKE_EN
    // Brake lights every lamp the sweep is not using; hazard flash wins.
    if (req[BTN_BRAKE]) begin
      case (state_q)
        IDLE: begin
          left_leds  = '1;
          right_leds = '1;
        end
        LEFT:    right_leds = '1;
        RIGHT:   left_leds  = '1;
        default: begin
          left_leds  = left_leds;
          right_leds = right_leds;
        end
      endcase
    end
`endif
  end

endmodule

// File: tb/tb_tbird_seq_ctrl.sv
// tb/tb_tbird_seq_ctrl.sv - self-checking bench for tbird_seq_ctrl (N=3, STEP_TICKS=4)
module tb_tbird_seq_ctrl;

  localparam int N    = 3;
  localparam int STEP = 4;

  logic         clock = 1'b0;
  logic         reset;
  logic         left_btn_n;
  logic         right_btn_n;
  logic         hazard_btn_n;
  logic         brake_btn_n;
  logic [N-1:0] left_leds;
  logic [N-1:0] right_leds;
  logic [1:0]   state_o;

  int checks   = 0;
  int failures = 0;
  bit mchk     = 1'b0;

  always #5 clock = ~clock;

  tbird_seq_ctrl #(
    .LEDS_PER_SIDE (N),
    .STEP_TICKS    (STEP)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .left_btn_n   (left_btn_n),
    .right_btn_n  (right_btn_n),
    .hazard_btn_n (hazard_btn_n),
`ifdef TBIRD_BRAKE_EN
    .brake_btn_n  (brake_btn_n),
`endif
    .left_leds    (left_leds),
    .right_leds   (right_leds),
    .state_o      (state_o)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: actual=%0h required=%0h", nm, $time, act, exp);
    end
  endtask

  // presses are active-high here: {brake, hazard, right, left}
  task automatic apply(input logic [3:0] p);
    left_btn_n   = ~p[0];
    right_btn_n  = ~p[1];
    hazard_btn_n = ~p[2];
    brake_btn_n  = ~p[3];
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: mode plus cycles spent in it; lamps follow from elapsed
  // time divided into STEP-long steps. Requests are the buttons delayed by
  // two clock edges.
  // ---------------------------------------------------------------------------
  int         m_mode;
  int         m_t;
  logic [3:0] m_pipe0;
  logic [3:0] m_pipe1;
  int         m_next;
  logic       m_l;
  logic       m_r;
  logic       m_h;

  always @(posedge clock) begin
    if (reset) begin
      m_mode  = 0;
      m_t     = 0;
      m_pipe0 = 4'b0;
      m_pipe1 = 4'b0;
    end else begin
      m_l    = m_pipe1[0];
      m_r    = m_pipe1[1];
      m_h    = m_pipe1[2];
      m_next = m_mode;
      case (m_mode)
        0: begin
          if (m_h || (m_l && m_r)) m_next = 3;
          else if (m_l)            m_next = 1;
          else if (m_r)            m_next = 2;
        end
        1, 2: begin
          if (m_h)                          m_next = 3;
          else if (m_t == (N+1)*STEP - 1)   m_next = 0;
        end
        default: begin
          if (!m_h && !(m_l && m_r)) m_next = 0;
        end
      endcase
      m_t     = (m_next != m_mode) ? 0 : m_t + 1;
      m_mode  = m_next;
      m_pipe1 = m_pipe0;
      m_pipe0 = ~{brake_btn_n, hazard_btn_n, right_btn_n, left_btn_n};
    end
  end

  function automatic void model_out(output logic [N-1:0] el, output logic [N-1:0] er);
    int k;
    logic [N-1:0] th;
    k  = m_t / STEP;
    th = '0;
    for (int i = 0; i < N; i++) th[i] = (i < k);
    el = '0;
    er = '0;
    if (m_mode == 1) el = th;
    if (m_mode == 2) er = th;
    if (m_mode == 3) begin
      el = (k % 2 == 0) ? '1 : '0;
      er = el;
    end
`ifdef TBIRD_BRAKE_EN
    if (m_pipe1[3]) begin
      if (m_mode == 0 || m_mode == 2) el = '1;
      if (m_mode == 0 || m_mode == 1) er = '1;
    end
`endif
  endfunction

  logic [N-1:0] exp_l;
  logic [N-1:0] exp_r;

  always @(negedge clock) begin
    if (mchk) begin
      model_out(exp_l, exp_r);
      check("model_state", 32'(state_o), 32'(m_mode));
      check("model_left_leds", 32'(left_leds), 32'(exp_l));
      check("model_right_leds", 32'(right_leds), 32'(exp_r));
    end
  end

  // ---------------------------------------------------------------------------
  // Directed vectors: hold presses for n cycles, then compare.
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [3:0] btn;
    int         n;
    logic [1:0] st;
    logic [N-1:0] el;
    logic [N-1:0] er;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic [3:0] b, input int n, input logic [1:0] st,
                              input logic [N-1:0] el, input logic [N-1:0] er);
    vec_t v;
    v.btn = b; v.n = n; v.st = st; v.el = el; v.er = er;
    vecs.push_back(v);
  endfunction

  localparam logic [3:0] P0 = 4'b0000;
  localparam logic [3:0] PL = 4'b0001;
  localparam logic [3:0] PR = 4'b0010;
  localparam logic [3:0] PH = 4'b0100;
  localparam logic [3:0] PB = 4'b1000;

  logic [3:0] rp;
  int         hold;

  initial begin
    reset = 1'b1;
    apply(4'b1111);

    // reset with every button held low
    @(negedge clock);
    check("reset_state", 32'(state_o), 32'd0);
    check("reset_leds", 32'({left_leds, right_leds}), 32'd0);
    mchk = 1'b1;
    @(negedge clock);
    check("reset_state2", 32'(state_o), 32'd0);
    reset = 1'b0;
    @(negedge clock);
    check("post_reset_state", 32'(state_o), 32'd0);
    check("post_reset_leds", 32'({left_leds, right_leds}), 32'd0);
    apply(P0);
    repeat (8) @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;

    // single-cycle left press
    add(PL, 1, 2'd0, 3'b000, 3'b000);
    add(P0, 1, 2'd0, 3'b000, 3'b000);
    add(P0, 1, 2'd1, 3'b000, 3'b000);
    add(P0, 3, 2'd1, 3'b000, 3'b000);
    add(P0, 1, 2'd1, 3'b001, 3'b000);
    add(P0, 3, 2'd1, 3'b001, 3'b000);
    add(P0, 1, 2'd1, 3'b011, 3'b000);
    add(P0, 4, 2'd1, 3'b111, 3'b000);
    add(P0, 3, 2'd1, 3'b111, 3'b000);
    add(P0, 1, 2'd0, 3'b000, 3'b000);
    // right held, left pressed mid-sweep, restart after one idle cycle
    add(PR, 1, 2'd0, 3'b000, 3'b000);
    add(PR, 1, 2'd0, 3'b000, 3'b000);
    add(PR, 1, 2'd2, 3'b000, 3'b000);
    add(PR, 8, 2'd2, 3'b000, 3'b011);
    add(PR | PL, 4, 2'd2, 3'b000, 3'b111);
    add(PR, 3, 2'd2, 3'b000, 3'b111);
    add(PR, 1, 2'd0, 3'b000, 3'b000);
    add(PR, 1, 2'd2, 3'b000, 3'b000);
    // hazard during RIGHT at phase 2
    add(PR, 8, 2'd2, 3'b000, 3'b011);
    add(PR | PH, 1, 2'd2, 3'b000, 3'b011);
    add(PR | PH, 1, 2'd2, 3'b000, 3'b011);
    add(PR | PH, 1, 2'd3, 3'b111, 3'b111);
    add(PH, 3, 2'd3, 3'b111, 3'b111);
    add(PH, 1, 2'd3, 3'b000, 3'b000);
    add(PH, 3, 2'd3, 3'b000, 3'b000);
    add(PH, 1, 2'd3, 3'b111, 3'b111);
    add(P0, 1, 2'd3, 3'b111, 3'b111);
    add(P0, 1, 2'd3, 3'b111, 3'b111);
    add(P0, 1, 2'd0, 3'b000, 3'b000);
    // left and right together from IDLE
    add(PL | PR, 1, 2'd0, 3'b000, 3'b000);
    add(PL | PR, 1, 2'd0, 3'b000, 3'b000);
    add(PL | PR, 1, 2'd3, 3'b111, 3'b111);
    add(PL | PR, 4, 2'd3, 3'b000, 3'b000);
    add(PL | PR, 4, 2'd3, 3'b111, 3'b111);
    add(P0, 2, 2'd3, 3'b111, 3'b111);
    add(P0, 1, 2'd0, 3'b000, 3'b000);
`ifdef TBIRD_BRAKE_EN
    add(PB, 2, 2'd0, 3'b111, 3'b111);
    add(PB | PL, 2, 2'd0, 3'b111, 3'b111);
    add(PB, 1, 2'd1, 3'b000, 3'b111);
    add(PB, 4, 2'd1, 3'b001, 3'b111);
    add(PB, 4, 2'd1, 3'b011, 3'b111);
    add(PB, 4, 2'd1, 3'b111, 3'b111);
    add(PB, 4, 2'd0, 3'b111, 3'b111);
    add(P0, 1, 2'd0, 3'b111, 3'b111);
    add(P0, 1, 2'd0, 3'b000, 3'b000);
`endif

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i].btn);
      repeat (vecs[i].n) @(negedge clock);
      check($sformatf("vec%0d_state", i), 32'(state_o), 32'(vecs[i].st));
      check($sformatf("vec%0d_left", i), 32'(left_leds), 32'(vecs[i].el));
      check($sformatf("vec%0d_right", i), 32'(right_leds), 32'(vecs[i].er));
    end

    // randomized presses, occasional mid-sequence reset, checked by the model
    for (int k = 0; k < 160; k++) begin
      rp    = P0;
      rp[0] = ($urandom_range(0, 2) == 0);
      rp[1] = ($urandom_range(0, 2) == 0);
      rp[2] = ($urandom_range(0, 5) == 0);
`ifdef TBIRD_BRAKE_EN
      rp[3] = ($urandom_range(0, 2) == 0);
`endif
      apply(rp);
      hold = $urandom_range(1, 24);
      repeat (hold) @(negedge clock);
      if ($urandom_range(0, 12) == 0) begin
        reset = 1'b1;
        @(negedge clock);
        check("midseq_reset_state", 32'(state_o), 32'd0);
        check("midseq_reset_leds", 32'({left_leds, right_leds}), 32'd0);
        reset = 1'b0;
      end
    end

    apply(P0);
    repeat (4) @(negedge clock);
    mchk = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
